// File: rtl/timer_pkg.sv
// Shared definitions for the timer bank: mode encodings and the mode field width.
package timer_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_STOP     = 2'd0,
    MODE_ONESHOT  = 2'd1,
    MODE_PERIODIC = 2'd2,
    MODE_RSVD     = 2'd3
  } mode_t;

  // A channel is armed only by the two running modes; the reserved code acts as STOP.
  function automatic logic mode_runs(input mode_t m);
    return (m == MODE_ONESHOT) || (m == MODE_PERIODIC);
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One down-counting timer channel: counter, reload register, mode register,
// busy flag and a registered one-cycle tick.
module timer_channel
  import timer_pkg::*;
#(
  parameter int COUNT_WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  mode_t                  load_mode,
  input  logic [COUNT_WIDTH-1:0] load_value,
  input  logic                   advance,
  output logic                   busy,
  output logic                   tick
);

  logic [COUNT_WIDTH-1:0] count;
  logic [COUNT_WIDTH-1:0] reload;
  mode_t                  mode;

  // Load has priority over counting, so a write on the terminal edge suppresses the tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      reload <= '0;
      mode   <= MODE_STOP;
      busy   <= 1'b0;
      tick   <= 1'b0;
    end else if (load) begin
      count  <= load_value;
      reload <= load_value;
      mode   <= load_mode;
      busy   <= mode_runs(load_mode);
      tick   <= 1'b0;
    end else if (busy && advance) begin
      if (count != '0) begin
        count <= count - COUNT_WIDTH'(1);
        tick  <= 1'b0;
      end else begin
        tick <= 1'b1;
        if (mode == MODE_PERIODIC) begin
          count <= reload;
        end else begin
          busy <= 1'b0;
        end
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/timer_bank.sv
// Bank of NUM_CHANNELS programmable down-counting timers with a shared
// single-cycle configuration write port.
// Optional feature: define TIMER_PRESCALE_EN to build a shared prescaler so
// counters advance once every PRESCALE clocks.
module timer_bank
  import timer_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int COUNT_WIDTH  = 24,
  parameter int CHAN_WIDTH   = 2,
  parameter int PRESCALE     = 8
) (
  input  logic                    clk_in,
  input  logic                    reset_in,
  input  logic [CHAN_WIDTH-1:0]   cfgChan_in,
  input  logic [MODE_W-1:0]       cfgMode_in,
  input  logic [COUNT_WIDTH-1:0]  cfgData_in,
  input  logic                    cfgWrite_in,
  input  logic [NUM_CHANNELS-1:0] en_in,
  output logic [NUM_CHANNELS-1:0] busy_out,
  output logic [NUM_CHANNELS-1:0] tick_out
);

  logic strobe;

`ifdef TIMER_PRESCALE_EN
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PRE_W-1:0] pre_cnt;

  // Strobe on the edge where the prescaler wraps back to zero.
  assign strobe = (pre_cnt == PRE_W'(PRESCALE - 1));

  // Free-running prescaler; writes never disturb it.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      pre_cnt <= '0;
    end else if (strobe) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end
`else
  // No prescaler: every enabled edge advances (PRESCALE is always >= 1).
  assign strobe = (PRESCALE != 0);
`endif

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
    logic load;

    // Channel select values with no matching channel simply decode to nothing.
    assign load = cfgWrite_in && (cfgChan_in == CHAN_WIDTH'(c));

    timer_channel #(
      .COUNT_WIDTH(COUNT_WIDTH)
    ) u_chan (
      .clk       (clk_in),
      .rst       (reset_in),
      .load      (load),
      .load_mode (mode_t'(cfgMode_in)),
      .load_value(cfgData_in),
      .advance   (en_in[c] & strobe),
      .busy      (busy_out[c]),
      .tick      (tick_out[c])
    );
  end

endmodule

// File: tb/tb_timer_bank.sv
// Scoreboard bench for timer_bank: stimulus drives inputs on the falling edge
// and pushes the reference model's expected outputs; a monitor pops and
// compares just after each rising edge.
module tb_timer_bank;

  localparam int NC  = 3;   // fewer channels than select codes, so code 3 is unmapped
  localparam int CW  = 24;
  localparam int CHW = 2;
  localparam int PS  = 8;

  logic           clk = 1'b0;
  logic           reset_in = 1'b1;
  logic [CHW-1:0] cfgChan_in = '0;
  logic [1:0]     cfgMode_in = '0;
  logic [CW-1:0]  cfgData_in = '0;
  logic           cfgWrite_in = 1'b0;
  logic [NC-1:0]  en_in = '0;
  logic [NC-1:0]  busy_out;
  logic [NC-1:0]  tick_out;

  timer_bank #(
    .NUM_CHANNELS(NC),
    .COUNT_WIDTH (CW),
    .CHAN_WIDTH  (CHW),
    .PRESCALE    (PS)
  ) dut (
    .clk_in     (clk),
    .reset_in   (reset_in),
    .cfgChan_in (cfgChan_in),
    .cfgMode_in (cfgMode_in),
    .cfgData_in (cfgData_in),
    .cfgWrite_in(cfgWrite_in),
    .en_in      (en_in),
    .busy_out   (busy_out),
    .tick_out   (tick_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [2*NC-1:0] exp_q[$];

  // Reference model: per channel, the number of advances seen since arming.
  // A tick comes on the (R+1)-th advance after a write.
  bit m_armed[NC];
  bit m_per[NC];
  int m_r[NC];
  int m_seen[NC];
  int m_clk_since_rst;

  function automatic bit model_strobe();
`ifdef TIMER_PRESCALE_EN
    return (m_clk_since_rst % PS) == PS - 1;
`else
    return 1'b1;
`endif
  endfunction

  task automatic step(input bit wr, input int ch, input int md, input int d,
                      input logic [NC-1:0] en, input bit rst);
    logic [NC-1:0] eb, et;
    bit stb;
    @(negedge clk);
    cyc++;
    cfgWrite_in = wr;
    cfgChan_in  = CHW'(ch);
    cfgMode_in  = 2'(md);
    cfgData_in  = CW'(d);
    en_in       = en;
    if (rst && !reset_in) begin
      reset_in = 1'b1;
      #1;
      total++;
      if (busy_out !== '0 || tick_out !== '0) begin
        bad++;
        $display("FAIL async_reset cycle=%0d got busy=%b tick=%b want busy=0 tick=0",
                 cyc, busy_out, tick_out);
      end
    end
    reset_in = rst;
    et = '0;
    if (rst) begin
      for (int c = 0; c < NC; c++) begin
        m_armed[c] = 0; m_per[c] = 0; m_r[c] = 0; m_seen[c] = 0;
      end
      m_clk_since_rst = 0;
    end else begin
      stb = model_strobe();
      m_clk_since_rst++;
      for (int c = 0; c < NC; c++) begin
        if (wr && ch == c) begin
          m_r[c] = d; m_seen[c] = 0;
          m_per[c] = (md == 2);
          m_armed[c] = (md == 1 || md == 2);
        end else if (m_armed[c] && en[c] && stb) begin
          m_seen[c]++;
          if (m_seen[c] == m_r[c] + 1) begin
            et[c] = 1'b1;
            m_seen[c] = 0;
            if (!m_per[c]) m_armed[c] = 0;
          end
        end
      end
    end
    for (int c = 0; c < NC; c++) eb[c] = m_armed[c];
    exp_q.push_back({eb, et});
  endtask

  task automatic idle(input int n, input logic [NC-1:0] en);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, en, 0);
  endtask

  // Monitor: compare every presented output against the scoreboard head.
  initial begin
    logic [2*NC-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if ({busy_out, tick_out} !== e) begin
          bad++;
          $display("FAIL outputs cycle=%0d got busy=%b tick=%b want busy=%b tick=%b",
                   cyc, busy_out, tick_out, e[2*NC-1:NC], e[NC-1:0]);
        end
      end
    end
  end

  initial begin
    int guard;
    // Reset held, then 20 quiet cycles with everything enabled
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, '1, 1);
    idle(20, '1);

    // ch0 periodic R=4
    step(1, 0, 2, 4, '1, 0);
    idle(18, '1);

    // ch1 one-shot R=2, then quiet
    step(1, 1, 1, 2, '1, 0);
    idle(22, '1);

    // ch2 periodic R=3 with enable dropped mid-count
    step(1, 2, 2, 3, '1, 0);
    idle(2, '1);
    idle(5, 3'b011);
    idle(12, '1);

    // Rewrite ch0 on its terminal-count edge
    guard = 0;
    while (!(m_armed[0] && m_seen[0] == m_r[0] && model_strobe()) && guard < 200) begin
      idle(1, '1);
      guard++;
    end
    total++;
    if (guard >= 200) begin
      bad++;
      $display("FAIL terminal_search got guard=%0d want <200", guard);
    end
    step(1, 0, 2, 9, '1, 0);
    idle(25, '1);

    // Writing STOP aborts; reserved mode acts as STOP; unmapped channel ignored
    step(1, 2, 0, 0, '1, 0);
    step(1, 1, 3, 5, '1, 0);
    step(1, 3, 2, 1, '1, 0);
    idle(6, '1);

    // Periodic R=0 ticks every advance; R=1 periodic for prescale spacing
    step(1, 1, 2, 0, '1, 0);
    step(1, 2, 2, 1, '1, 0);
    idle(40, '1);

    // Reset mid-count
    step(0, 0, 0, 0, '1, 1);
    step(0, 0, 0, 0, '1, 1);
    idle(5, '1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [NC-1:0] en;
      bit wr, rs;
      for (int c = 0; c < NC; c++) en[c] = ($urandom_range(0, 7) != 0);
      wr = ($urandom_range(0, 9) == 0);
      rs = ($urandom_range(0, 299) == 0);
      step(wr, $urandom_range(0, 3), $urandom_range(0, 3),
           ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 6),
           en, rs);
    end

    idle(2, '1);
    @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got pending=%0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
